// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register and operand-select stage for a
//               32-bit MIPS-style ALU. Registers the decoded instruction
//               fields, decodes aluop/funct into the 4-bit ALU control code,
//               forwards EX/MEM and MEM/WB results onto the ALU operands,
//               detects load-use hazards, inserts bubbles, honours
//               flush/hold and counts load-use bubbles (saturating).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   hold                       downstream stall, EX contents frozen
//   flush                      discard the instruction presented by ID
//   id_valid                   ID presents an instruction
//   id_rs_data, id_rt_data     register-file operand values
//   id_imm16                   instruction immediate
//   id_rs, id_rt, id_rd        register addresses
//   id_funct, id_aluop         ALU operation select
//   id_alusrc, id_regdst       operand-b / destination select
//   id_regwrite, id_memread,
//   id_memwrite, id_memtoreg   control bits carried into EX
//   exmem_*, memwb_*           forwarding sources (write enable, addr, value)
//   stall_id                   hold PC and IF/ID this cycle (load-use)
//   ex_valid                   EX holds a real instruction
//   alu_a, alu_b, alu_ctrl     ALU operands and control code
//   ex_store_data              forwarded rt value for stores
//   ex_wa                      destination register
//   ex_regwrite, ex_memread,
//   ex_memwrite, ex_memtoreg   controls, gated by ex_valid
//   bubble_cnt                 load-use bubbles inserted, saturating
// ============================================================================
module id_ex_stage #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm16,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic [5:0]    id_funct,
    input  logic [1:0]    id_aluop,
    input  logic          id_alusrc,
    input  logic          id_regdst,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          exmem_regwrite,
    input  logic [4:0]    exmem_wa,
    input  logic [DW-1:0] exmem_res,
    input  logic          memwb_regwrite,
    input  logic [4:0]    memwb_wa,
    input  logic [DW-1:0] memwb_res,
    output logic          stall_id,
    output logic          ex_valid,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_ctrl,
    output logic [DW-1:0] ex_store_data,
    output logic [4:0]    ex_wa,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic [CW-1:0] bubble_cnt
);

    // ALU control codes
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_BAD = 4'b1111;

    // aluop encodings
    localparam logic [1:0] c_OP_ADD  = 2'b00;
    localparam logic [1:0] c_OP_SUB  = 2'b01;
    localparam logic [1:0] c_OP_RTYP = 2'b10;
    localparam logic [1:0] c_OP_ORI  = 2'b11;

    // R-type funct encodings
    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    localparam logic [CW-1:0] c_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    // EX-stage registers
    logic          r_ex_valid;
    logic          r_regwrite;
    logic          r_memread;
    logic          r_memwrite;
    logic          r_memtoreg;
    logic          r_alusrc;
    logic [3:0]    r_alu_ctrl;
    logic [4:0]    r_ex_wa;
    logic [4:0]    r_rs;
    logic [4:0]    r_rt;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [DW-1:0] r_imm_ext;
    logic [CW-1:0] r_bubble_cnt;

    // Decode-side combinational values resolved at capture
    logic [3:0]    w_alu_ctrl;
    logic [DW-1:0] w_imm_ext;
    logic [4:0]    w_wa;
    logic          w_stall;

    // Forwarding
    logic          w_fwd_rs_exmem;
    logic          w_fwd_rs_memwb;
    logic          w_fwd_rt_exmem;
    logic          w_fwd_rt_memwb;
    logic [DW-1:0] w_rs_fwd;
    logic [DW-1:0] w_rt_fwd;

    always_comb begin
        w_alu_ctrl = c_ALU_BAD;
        case (id_aluop)
            c_OP_ADD: w_alu_ctrl = c_ALU_ADD;
            c_OP_SUB: w_alu_ctrl = c_ALU_SUB;
            c_OP_ORI: w_alu_ctrl = c_ALU_OR;
            c_OP_RTYP: begin
                case (id_funct)
                    c_FN_ADD: w_alu_ctrl = c_ALU_ADD;
                    c_FN_SUB: w_alu_ctrl = c_ALU_SUB;
                    c_FN_AND: w_alu_ctrl = c_ALU_AND;
                    c_FN_OR:  w_alu_ctrl = c_ALU_OR;
                    c_FN_SLT: w_alu_ctrl = c_ALU_SLT;
                    // Unknown funct: code the ALU treats as "result 0"
                    default:  w_alu_ctrl = c_ALU_BAD;
                endcase
            end
            default: w_alu_ctrl = c_ALU_BAD;
        endcase
    end

    // ori is a logical op, so its immediate is zero-extended
    assign w_imm_ext = (id_aluop == c_OP_ORI) ? {{(DW-16){1'b0}}, id_imm16}
                                              : {{(DW-16){id_imm16[15]}}, id_imm16};

    assign w_wa = id_regdst ? id_rd : id_rt;

    // A load in EX whose destination is read by the instruction in ID cannot
    // be forwarded in time; stall ID one cycle. Suppressed under hold since
    // nothing moves anyway and the bubble must not be counted.
    assign w_stall = !hold && r_ex_valid && r_memread && (r_ex_wa != 5'd0) &&
                     id_valid && ((r_ex_wa == id_rs) || (r_ex_wa == id_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_regwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_alusrc     <= 1'b0;
            r_alu_ctrl   <= 4'b0000;
            r_ex_wa      <= 5'd0;
            r_rs         <= 5'd0;
            r_rt         <= 5'd0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm_ext    <= '0;
            r_bubble_cnt <= '0;
        end else if (!hold) begin
            if (flush || w_stall) begin
                // Bubble: only validity and side-effect controls are cleared
                r_ex_valid <= 1'b0;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
                r_memtoreg <= 1'b0;
                // Only load-use bubbles are counted; flush takes priority
                if (!flush && (r_bubble_cnt != {CW{1'b1}})) begin
                    r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
                end
            end else begin
                r_ex_valid <= id_valid;
                r_regwrite <= id_regwrite;
                r_memread  <= id_memread;
                r_memwrite <= id_memwrite;
                r_memtoreg <= id_memtoreg;
                r_alusrc   <= id_alusrc;
                r_alu_ctrl <= w_alu_ctrl;
                r_ex_wa    <= w_wa;
                r_rs       <= id_rs;
                r_rt       <= id_rt;
                r_rs_data  <= id_rs_data;
                r_rt_data  <= id_rt_data;
                r_imm_ext  <= w_imm_ext;
            end
        end
    end

    // Register 0 is hard-wired zero, so a write to it is never forwarded.
    // EX/MEM is younger than MEM/WB and therefore wins when both match.
    assign w_fwd_rs_exmem = exmem_regwrite && (exmem_wa == r_rs) && (r_rs != 5'd0);
    assign w_fwd_rs_memwb = memwb_regwrite && (memwb_wa == r_rs) && (r_rs != 5'd0);
    assign w_fwd_rt_exmem = exmem_regwrite && (exmem_wa == r_rt) && (r_rt != 5'd0);
    assign w_fwd_rt_memwb = memwb_regwrite && (memwb_wa == r_rt) && (r_rt != 5'd0);

    assign w_rs_fwd = w_fwd_rs_exmem ? exmem_res :
                      w_fwd_rs_memwb ? memwb_res : r_rs_data;
    assign w_rt_fwd = w_fwd_rt_exmem ? exmem_res :
                      w_fwd_rt_memwb ? memwb_res : r_rt_data;

    assign stall_id      = w_stall;
    assign ex_valid      = r_ex_valid;
    assign alu_a         = w_rs_fwd;
    assign alu_b         = r_alusrc ? r_imm_ext : w_rt_fwd;
    assign alu_ctrl      = r_alu_ctrl;
    assign ex_store_data = w_rt_fwd;
    assign ex_wa         = r_ex_wa;
    assign ex_regwrite   = r_regwrite & r_ex_valid;
    assign ex_memread    = r_memread  & r_ex_valid;
    assign ex_memwrite   = r_memwrite & r_ex_valid;
    assign ex_memtoreg   = r_memtoreg & r_ex_valid;
    assign bubble_cnt    = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. Expected EX contents are
//               queued when an instruction is presented and compared after
//               the capturing clock edge. The bubble counter is shrunk to
//               3 bits so saturation is reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int c_DW = 32;
    localparam int c_CW = 3;

    logic            clk;
    logic            rst_n;
    logic            hold;
    logic            flush;
    logic            id_valid;
    logic [c_DW-1:0] id_rs_data;
    logic [c_DW-1:0] id_rt_data;
    logic [15:0]     id_imm16;
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic [4:0]      id_rd;
    logic [5:0]      id_funct;
    logic [1:0]      id_aluop;
    logic            id_alusrc;
    logic            id_regdst;
    logic            id_regwrite;
    logic            id_memread;
    logic            id_memwrite;
    logic            id_memtoreg;
    logic            exmem_regwrite;
    logic [4:0]      exmem_wa;
    logic [c_DW-1:0] exmem_res;
    logic            memwb_regwrite;
    logic [4:0]      memwb_wa;
    logic [c_DW-1:0] memwb_res;
    logic            stall_id;
    logic            ex_valid;
    logic [c_DW-1:0] alu_a;
    logic [c_DW-1:0] alu_b;
    logic [3:0]      alu_ctrl;
    logic [c_DW-1:0] ex_store_data;
    logic [4:0]      ex_wa;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memwrite;
    logic            ex_memtoreg;
    logic [c_CW-1:0] bubble_cnt;

    id_ex_stage #(.DW(c_DW), .CW(c_CW)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hold           (hold),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_imm16       (id_imm16),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_funct       (id_funct),
        .id_aluop       (id_aluop),
        .id_alusrc      (id_alusrc),
        .id_regdst      (id_regdst),
        .id_regwrite    (id_regwrite),
        .id_memread     (id_memread),
        .id_memwrite    (id_memwrite),
        .id_memtoreg    (id_memtoreg),
        .exmem_regwrite (exmem_regwrite),
        .exmem_wa       (exmem_wa),
        .exmem_res      (exmem_res),
        .memwb_regwrite (memwb_regwrite),
        .memwb_wa       (memwb_wa),
        .memwb_res      (memwb_res),
        .stall_id       (stall_id),
        .ex_valid       (ex_valid),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_ctrl       (alu_ctrl),
        .ex_store_data  (ex_store_data),
        .ex_wa          (ex_wa),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .ex_memtoreg    (ex_memtoreg),
        .bubble_cnt     (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected EX contents; ctl = {regwrite, memread, memwrite, memtoreg}
    typedef struct {
        string       tag;
        logic        bub;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  wa;
        logic [3:0]  ctl;
        logic [31:0] sd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;
    int   exp_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_ins(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] ctrl, input logic [4:0] wa,
                            input logic [3:0] ctl, input logic [31:0] sd);
        exp_t e;
        e.tag = tag; e.bub = 1'b0; e.a = a; e.b = b;
        e.ctrl = ctrl; e.wa = wa; e.ctl = ctl; e.sd = sd;
        sb.push_back(e);
    endtask

    task automatic push_bub(input string tag);
        exp_t e;
        e.tag = tag; e.bub = 1'b1; e.a = '0; e.b = '0;
        e.ctrl = '0; e.wa = '0; e.ctl = '0; e.sd = '0;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".valid"}, {31'd0, ex_valid}, {31'd0, ~e.bub});
            check({e.tag, ".ctl"}, {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
                  {28'd0, e.ctl});
            if (!e.bub) begin
                check({e.tag, ".alu_a"}, alu_a, e.a);
                check({e.tag, ".alu_b"}, alu_b, e.b);
                check({e.tag, ".ctrl"}, {28'd0, alu_ctrl}, {28'd0, e.ctrl});
                check({e.tag, ".wa"}, {27'd0, ex_wa}, {27'd0, e.wa});
                check({e.tag, ".sd"}, ex_store_data, e.sd);
            end
        end
    endtask

    task automatic set_id(input logic v, input logic [1:0] aluop, input logic [5:0] funct,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm,
                          input logic alusrc, input logic regdst, input logic rw,
                          input logic mr, input logic mw, input logic mt);
        id_valid = v; id_aluop = aluop; id_funct = funct;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm16 = imm;
        id_alusrc = alusrc; id_regdst = regdst;
        id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_memtoreg = mt;
    endtask

    task automatic set_fwd(input logic erw, input logic [4:0] ewa, input logic [31:0] eres,
                           input logic mrw, input logic [4:0] mwa, input logic [31:0] mres);
        exmem_regwrite = erw; exmem_wa = ewa; exmem_res = eres;
        memwb_regwrite = mrw; memwb_wa = mwa; memwb_res = mres;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lw $5, 4($1)
    task automatic drive_lw5();
        set_id(1'b1, 2'b00, 6'd0, 5'd1, 5'd5, 5'd0, 32'h100, 32'h0, 16'd4,
               1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    // add $7, $5, $6
    task automatic drive_add_dep();
        set_id(1'b1, 2'b10, 6'b100000, 5'd5, 5'd6, 5'd7, 32'h0, 32'h66, 16'd0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    logic [5:0] fn_tab [5];
    logic [3:0] ct_tab [5];

    initial begin
        n_cmp = 0;
        n_err = 0;
        fn_tab[0] = 6'b100000; ct_tab[0] = 4'b0010;
        fn_tab[1] = 6'b100100; ct_tab[1] = 4'b0000;
        fn_tab[2] = 6'b100101; ct_tab[2] = 4'b0001;
        fn_tab[3] = 6'b101010; ct_tab[3] = 4'b0111;
        fn_tab[4] = 6'b000000; ct_tab[4] = 4'b1111;

        rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
        set_id(1'b0, 2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        // Reset state
        check("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst.ctl", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}, 32'd0);
        check("rst.alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("rst.ex_wa", {27'd0, ex_wa}, 32'd0);
        check("rst.bubble_cnt", {29'd0, bubble_cnt}, 32'd0);
        check("rst.stall_id", {31'd0, stall_id}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // sub with rs=7, rt=3 data, no hazards
        set_id(1'b1, 2'b10, 6'b100010, 5'd1, 5'd2, 5'd3, 32'd7, 32'd3, 16'd0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_ins("t1_sub", 32'd7, 32'd3, 4'b0110, 5'd3, 4'b1000, 32'd3);
        tick(); pop_check();

        // Remaining R-type funct decodes, including an unknown funct
        for (int i = 0; i < 5; i++) begin
            set_id(1'b1, 2'b10, fn_tab[i], 5'd1, 5'd2, 5'd4, 32'h10 + i, 32'h20 + i, 16'd0,
                   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            push_ins($sformatf("t1_fn%0d", i), 32'h10 + i, 32'h20 + i, ct_tab[i], 5'd4,
                     4'b1000, 32'h20 + i);
            tick(); pop_check();
        end

        // Load-use: lw $5 in EX, add using $5 in ID
        drive_lw5();
        push_ins("t2_lw", 32'h100, 32'd4, 4'b0010, 5'd5, 4'b1101, 32'h0);
        tick(); pop_check();
        drive_add_dep();
        #1;
        check("t2.stall", {31'd0, stall_id}, 32'd1);
        hold = 1'b1; #1;
        check("t2.stall_hold", {31'd0, stall_id}, 32'd0);
        hold = 1'b0; #1;
        push_bub("t2_bubble");
        tick(); pop_check();
        check("t2.bubble_cnt", {29'd0, bubble_cnt}, 32'd1);
        check("t2.stall_after", {31'd0, stall_id}, 32'd0);
        // add enters; the loaded value arrives via MEM/WB
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h55);
        push_ins("t2_add", 32'h55, 32'h66, 4'b0010, 5'd7, 4'b1000, 32'h66);
        tick(); pop_check();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Flush outranks a load-use stall: bubble is not counted
        drive_lw5();
        push_ins("tf_lw", 32'h100, 32'd4, 4'b0010, 5'd5, 4'b1101, 32'h0);
        tick(); pop_check();
        drive_add_dep();
        flush = 1'b1; #1;
        check("tf.stall", {31'd0, stall_id}, 32'd1);
        push_bub("tf_bubble");
        tick(); pop_check();
        check("tf.bubble_cnt", {29'd0, bubble_cnt}, 32'd1);
        flush = 1'b0;

        // Counter saturation
        exp_cnt = 1;
        for (int i = 0; i < 8; i++) begin
            drive_lw5();
            tick();
            drive_add_dep();
            tick();
            exp_cnt = (exp_cnt == 7) ? 7 : exp_cnt + 1;
            check($sformatf("sat.cnt%0d", i), {29'd0, bubble_cnt}, exp_cnt);
        end

        // Forwarding priority on rs
        set_fwd(1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB);
        set_id(1'b1, 2'b10, 6'b100000, 5'd4, 5'd9, 5'd10, 32'h11, 32'h22, 16'd0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_ins("t3_both", 32'hAA, 32'h22, 4'b0010, 5'd10, 4'b1000, 32'h22);
        tick(); pop_check();
        exmem_regwrite = 1'b0; #1;
        check("t3.memwb_only", alu_a, 32'hBB);
        memwb_regwrite = 1'b0; #1;
        check("t3.no_fwd", alu_a, 32'h11);

        // Store: rt forwarded to store data, b takes the immediate
        set_fwd(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 2'b00, 6'd0, 5'd2, 5'd9, 5'd0, 32'h1000, 32'h22, 16'd8,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push_ins("t3_sw", 32'h1000, 32'd8, 4'b0010, 5'd9, 4'b0010, 32'h77);
        tick(); pop_check();

        // Register 0 never forwarded
        set_fwd(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hFF);
        set_id(1'b1, 2'b10, 6'b100000, 5'd0, 5'd0, 5'd11, 32'h33, 32'h44, 16'd0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_ins("t4_r0", 32'h33, 32'h44, 4'b0010, 5'd11, 4'b1000, 32'h44);
        tick(); pop_check();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Hold with flush: EX frozen, then flush acts once hold drops
        set_id(1'b1, 2'b01, 6'd0, 5'd1, 5'd2, 5'd8, 32'h50, 32'h10, 16'd0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_ins("t5_x", 32'h50, 32'h10, 4'b0110, 5'd8, 4'b1000, 32'h10);
        tick(); pop_check();
        hold = 1'b1; flush = 1'b1;
        set_id(1'b1, 2'b11, 6'd0, 5'd3, 5'd4, 5'd9, 32'h999, 32'h888, 16'h1234,
               1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            push_ins($sformatf("t5_hold%0d", i), 32'h50, 32'h10, 4'b0110, 5'd8, 4'b1000, 32'h10);
            tick(); pop_check();
        end
        hold = 1'b0;
        push_bub("t5_flush");
        tick(); pop_check();
        flush = 1'b0;

        // Immediate extension
        set_id(1'b1, 2'b11, 6'd0, 5'd1, 5'd12, 5'd0, 32'h0, 32'h5, 16'h8000,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push_ins("t6_ori", 32'h0, 32'h00008000, 4'b0001, 5'd12, 4'b1000, 32'h5);
        tick(); pop_check();
        set_id(1'b1, 2'b00, 6'd0, 5'd1, 5'd12, 5'd0, 32'h0, 32'h5, 16'h8000,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push_ins("t6_addi", 32'h0, 32'hFFFF8000, 4'b0010, 5'd12, 4'b1000, 32'h5);
        tick(); pop_check();

        // Reset during a load-use stall
        drive_lw5();
        tick();
        drive_add_dep();
        #1;
        check("rs.stall_before", {31'd0, stall_id}, 32'd1);
        rst_n = 1'b0; #1;
        check("rs.stall", {31'd0, stall_id}, 32'd0);
        check("rs.ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rs.bubble_cnt", {29'd0, bubble_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        check("sb.drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
